// File: rtl/decode_sequencer.sv
// Byte-serial x86-style instruction decoder: walks prefix, opcode, ModRM, SIB,
// displacement and immediate bytes, then holds the decoded fields until taken.
module decode_sequencer #(
    parameter int unsigned MAX_LEN = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic [7:0]  tbl_idx,
    output logic        tbl_esc,
    input  logic [23:0] tbl_info,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [7:0]  dec_opcode,
    output logic        dec_esc,
    output logic [23:0] dec_info,
    output logic [3:0]  dec_rex,
    output logic        dec_opsz16,
    output logic [1:0]  dec_rep,
    output logic        dec_lock,
    output logic [7:0]  dec_modrm,
    output logic [7:0]  dec_sib,
    output logic        dec_has_modrm,
    output logic        dec_has_sib,
    output logic [31:0] dec_disp,
    output logic [63:0] dec_imm,
    output logic [3:0]  dec_len,
    output logic        dec_err
);
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_PFX, S_OPC, S_MODRM, S_SIB, S_DISP, S_IMM, S_EMIT
    } state_t;

    typedef struct packed {
        logic [7:0]       opcode;
        logic             esc;
        logic [23:0]      info;
        logic [3:0]       rex;
        logic             opsz16;
        logic [1:0]       rep;
        logic             lock;
        logic [7:0]       modrm;
        logic [7:0]       sib;
        logic             has_modrm;
        logic             has_sib;
        logic [31:0]      disp;
        logic [63:0]      imm;
        logic [LEN_W-1:0] len;
        logic             err;
    } dec_t;

    state_t           r_state, w_state_nxt;
    dec_t             r_dec, w_dec_nxt;
    logic             r_valid, w_valid_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_disp_len, w_disp_len_nxt;
    logic [CNT_W-1:0] r_imm_len, w_imm_len_nxt;

    logic             w_opc_byte;
    logic             w_is_legacy;
    logic [1:0]       w_numop, w_kind1, w_kind2;
    logic             w_imm1, w_imm2, w_need_modrm;
    logic [CNT_W-1:0] w_opc_imm_len, w_mod_disp, w_cnt_inc;
    logic [1:0]       w_mod;
    logic [2:0]       w_rm;

    function automatic logic [CNT_W-1:0] imm_bytes(input logic [1:0] sz, input logic rex_w);
        case (sz)
            2'b00:   imm_bytes = CNT_W'(1);
            2'b01:   imm_bytes = CNT_W'(2);
            2'b10:   imm_bytes = CNT_W'(4);
            default: imm_bytes = rex_w ? CNT_W'(8) : CNT_W'(4);
        endcase
    endfunction

    // First non-empty trailing phase once ModRM/SIB are known.
    function automatic state_t tail_state(input logic [CNT_W-1:0] d_len, input logic [CNT_W-1:0] i_len);
        if (d_len != '0)      tail_state = S_DISP;
        else if (i_len != '0) tail_state = S_IMM;
        else                  tail_state = S_EMIT;
    endfunction

    assign w_is_legacy = in_byte inside {8'h66, 8'hF2, 8'hF3, 8'hF0,
                                         8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    assign w_numop       = tbl_info[22:21];
    assign w_kind1       = tbl_info[20:19];
    assign w_kind2       = tbl_info[18:17];
    assign w_need_modrm  = ((w_numop != 2'd0) && !w_kind1[1]) || ((w_numop >= 2'd2) && !w_kind2[1]);
    assign w_imm1        = (w_numop != 2'd0) && (w_kind1 == 2'b10);
    assign w_imm2        = (w_numop >= 2'd2) && (w_kind2 == 2'b10);
    assign w_opc_imm_len = w_imm1 ? imm_bytes(tbl_info[16:15], r_dec.rex[3]) :
                           w_imm2 ? imm_bytes(tbl_info[14:13], r_dec.rex[3]) : '0;
    assign w_mod         = in_byte[7:6];
    assign w_rm          = in_byte[2:0];
    assign w_mod_disp    = (w_mod == 2'b01) ? CNT_W'(1) : (w_mod == 2'b10) ? CNT_W'(4) : '0;
    assign w_cnt_inc     = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_PFX;
            r_dec      <= '0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
            r_disp_len <= '0;
            r_imm_len  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dec      <= w_dec_nxt;
            r_valid    <= w_valid_nxt;
            r_cnt      <= w_cnt_nxt;
            r_disp_len <= w_disp_len_nxt;
            r_imm_len  <= w_imm_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_dec_nxt      = r_dec;
        w_valid_nxt    = r_valid;
        w_cnt_nxt      = r_cnt;
        w_disp_len_nxt = r_disp_len;
        w_imm_len_nxt  = r_imm_len;
        w_opc_byte     = 1'b0;

        if (r_state == S_EMIT) begin
            if (dec_ready) begin
                w_state_nxt    = S_PFX;
                w_dec_nxt      = '0;
                w_valid_nxt    = 1'b0;
                w_cnt_nxt      = '0;
                w_disp_len_nxt = '0;
                w_imm_len_nxt  = '0;
            end
        end else if (in_valid) begin
            w_dec_nxt.len = r_dec.len + LEN_W'(1);
            case (r_state)
                S_PFX: begin
                    if (w_is_legacy) begin
                        w_dec_nxt.rex = '0;
                        case (in_byte)
                            8'h66:   w_dec_nxt.opsz16 = 1'b1;
                            8'hF3:   w_dec_nxt.rep    = 2'b01;
                            8'hF2:   w_dec_nxt.rep    = 2'b10;
                            8'hF0:   w_dec_nxt.lock   = 1'b1;
                            default: ;
                        endcase
                    end else if (in_byte[7:4] == 4'h4) begin
                        w_dec_nxt.rex = in_byte[3:0];
                    end else if (in_byte == 8'h0F) begin
                        w_dec_nxt.esc = 1'b1;
                        w_state_nxt   = S_OPC;
                    end else begin
                        w_opc_byte = 1'b1;
                    end
                end
                S_OPC: begin
                    if (in_byte == 8'h0F) w_dec_nxt.esc = 1'b1;
                    else                  w_opc_byte    = 1'b1;
                end
                S_MODRM: begin
                    w_dec_nxt.modrm     = in_byte;
                    w_dec_nxt.has_modrm = 1'b1;
                    w_cnt_nxt           = '0;
                    if ((w_mod != 2'b11) && (w_rm == 3'b100)) begin
                        w_disp_len_nxt = w_mod_disp;
                        w_state_nxt    = S_SIB;
                    end else begin
                        w_disp_len_nxt = ((w_mod == 2'b00) && (w_rm == 3'b101)) ? CNT_W'(4) : w_mod_disp;
                        w_state_nxt    = tail_state(w_disp_len_nxt, r_imm_len);
                    end
                end
                S_SIB: begin
                    w_dec_nxt.sib     = in_byte;
                    w_dec_nxt.has_sib = 1'b1;
                    if ((r_dec.modrm[7:6] == 2'b00) && (in_byte[2:0] == 3'b101))
                        w_disp_len_nxt = CNT_W'(4);
                    w_state_nxt = tail_state(w_disp_len_nxt, r_imm_len);
                end
                S_DISP: begin
                    // A lone disp8 is the only displacement that needs sign extension.
                    if (r_disp_len == CNT_W'(1))
                        w_dec_nxt.disp = {{24{in_byte[7]}}, in_byte};
                    else
                        w_dec_nxt.disp = r_dec.disp | (32'(in_byte) << {r_cnt[1:0], 3'b000});
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_disp_len) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_imm_len != '0) ? S_IMM : S_EMIT;
                    end
                end
                S_IMM: begin
                    w_dec_nxt.imm = r_dec.imm | (64'(in_byte) << {r_cnt[2:0], 3'b000});
                    w_cnt_nxt     = w_cnt_inc;
                    if (w_cnt_inc == r_imm_len) w_state_nxt = S_EMIT;
                end
                default: ;
            endcase

            if (w_opc_byte) begin
                w_dec_nxt.opcode = in_byte;
                w_dec_nxt.info   = tbl_info;
                w_cnt_nxt        = '0;
                if (tbl_info == '0) begin
                    w_dec_nxt.err = 1'b1;
                    w_state_nxt   = S_EMIT;
                end else begin
                    w_imm_len_nxt = w_opc_imm_len;
                    w_state_nxt   = w_need_modrm ? S_MODRM : tail_state('0, w_opc_imm_len);
                end
            end

            // Length overrun terminates the instruction with an error.
            if ((w_state_nxt != S_EMIT) && (w_dec_nxt.len == LEN_W'(MAX_LEN))) begin
                w_dec_nxt.err = 1'b1;
                w_state_nxt   = S_EMIT;
            end
            w_valid_nxt = (w_state_nxt == S_EMIT);
        end
    end

    assign in_ready      = (r_state != S_EMIT);
    assign tbl_idx       = ((r_state == S_PFX) || (r_state == S_OPC)) ? in_byte : 8'h00;
    assign tbl_esc       = r_dec.esc;
    assign dec_valid     = r_valid;
    assign dec_opcode    = r_dec.opcode;
    assign dec_esc       = r_dec.esc;
    assign dec_info      = r_dec.info;
    assign dec_rex       = r_dec.rex;
    assign dec_opsz16    = r_dec.opsz16;
    assign dec_rep       = r_dec.rep;
    assign dec_lock      = r_dec.lock;
    assign dec_modrm     = r_dec.modrm;
    assign dec_sib       = r_dec.sib;
    assign dec_has_modrm = r_dec.has_modrm;
    assign dec_has_sib   = r_dec.has_sib;
    assign dec_disp      = r_dec.disp;
    assign dec_imm       = r_dec.imm;
    assign dec_len       = r_dec.len;
    assign dec_err       = r_dec.err;

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: directed instruction byte streams with
// hand-computed decode results, checked by an independent output monitor.
module tb_decode_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic [7:0]  tbl_idx;
    logic        tbl_esc;
    logic [23:0] tbl_info;
    logic        dec_valid;
    logic        dec_ready;
    logic [7:0]  dec_opcode;
    logic        dec_esc;
    logic [23:0] dec_info;
    logic [3:0]  dec_rex;
    logic        dec_opsz16;
    logic [1:0]  dec_rep;
    logic        dec_lock;
    logic [7:0]  dec_modrm;
    logic [7:0]  dec_sib;
    logic        dec_has_modrm;
    logic        dec_has_sib;
    logic [31:0] dec_disp;
    logic [63:0] dec_imm;
    logic [3:0]  dec_len;
    logic        dec_err;

    typedef struct packed {
        logic [7:0]  opcode;
        logic        esc;
        logic [23:0] info;
        logic [3:0]  rex;
        logic        opsz16;
        logic [1:0]  rep;
        logic        lock;
        logic [7:0]  modrm;
        logic [7:0]  sib;
        logic        has_modrm;
        logic        has_sib;
        logic [31:0] disp;
        logic [63:0] imm;
        logic [3:0]  len;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] txq[$];
    int         n_vec = 0;
    int         n_err = 0;
    bit         gap = 1'b0;

    decode_sequencer #(.MAX_LEN(15)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .tbl_idx(tbl_idx), .tbl_esc(tbl_esc), .tbl_info(tbl_info),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_opcode(dec_opcode), .dec_esc(dec_esc), .dec_info(dec_info),
        .dec_rex(dec_rex), .dec_opsz16(dec_opsz16), .dec_rep(dec_rep), .dec_lock(dec_lock),
        .dec_modrm(dec_modrm), .dec_sib(dec_sib),
        .dec_has_modrm(dec_has_modrm), .dec_has_sib(dec_has_sib),
        .dec_disp(dec_disp), .dec_imm(dec_imm), .dec_len(dec_len), .dec_err(dec_err)
    );

    always #5 clk = ~clk;

    // Opcode-info table contents used by the scenarios.
    always_comb begin
        tbl_info = 24'h000000;
        if (!tbl_esc) begin
            case (tbl_idx)
                8'h01:   tbl_info = 24'hC9E000;
                8'hB8:   tbl_info = 24'h5DE000;
                8'h81:   tbl_info = 24'hCDC000;
                8'h90:   tbl_info = 24'h800000;
                default: tbl_info = 24'h000000;
            endcase
        end else if (tbl_idx == 8'hB6) begin
            tbl_info = 24'h438000;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (dec_valid && dec_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: opcode 0x%0h presented, no response expected", dec_opcode);
                end else begin
                    e = sb.pop_front();
                    check("opcode",    64'(dec_opcode),    64'(e.opcode));
                    check("esc",       64'(dec_esc),       64'(e.esc));
                    check("info",      64'(dec_info),      64'(e.info));
                    check("rex",       64'(dec_rex),       64'(e.rex));
                    check("opsz16",    64'(dec_opsz16),    64'(e.opsz16));
                    check("rep",       64'(dec_rep),       64'(e.rep));
                    check("lock",      64'(dec_lock),      64'(e.lock));
                    check("modrm",     64'(dec_modrm),     64'(e.modrm));
                    check("sib",       64'(dec_sib),       64'(e.sib));
                    check("has_modrm", 64'(dec_has_modrm), 64'(e.has_modrm));
                    check("has_sib",   64'(dec_has_sib),   64'(e.has_sib));
                    check("disp",      64'(dec_disp),      64'(e.disp));
                    check("imm",       dec_imm,            e.imm);
                    check("len",       64'(dec_len),       64'(e.len));
                    check("err",       64'(dec_err),       64'(e.err));
                end
            end
        end
    end

    task automatic send();
        int t;
        foreach (txq[i]) begin
            t = 0;
            while (!in_ready && t < 50) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) begin
                n_vec++;
                n_err++;
                $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, expected 1", t);
                in_valid = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_byte  = txq[i];
            @(posedge clk); #1;
            if (gap) begin
                in_valid = 1'b0;
                in_byte  = 8'hFF;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
    endtask

    initial begin : stimulus
        exp_t e;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_len",       64'(dec_len),   64'd0);
        check("rst_imm",       dec_imm,        64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // REX.W add reg,reg
        e = '0; e.opcode = 8'h01; e.info = 24'hC9E000; e.rex = 4'h8;
        e.modrm = 8'hD8; e.has_modrm = 1'b1; e.len = 4'd3;
        sb.push_back(e); txq = '{8'h48, 8'h01, 8'hD8}; send(); drain();

        // REX.W mov r64, imm64
        e = '0; e.opcode = 8'hB8; e.info = 24'h5DE000; e.rex = 4'h8;
        e.imm = 64'h1122334455667788; e.len = 4'd10;
        sb.push_back(e);
        txq = '{8'h48, 8'hB8, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        send(); drain();

        // mov r32, imm32 without REX.W: operand-size immediate is 4 bytes
        e = '0; e.opcode = 8'hB8; e.info = 24'h5DE000; e.imm = 64'h12345678; e.len = 4'd5;
        sb.push_back(e); txq = '{8'hB8, 8'h78, 8'h56, 8'h34, 8'h12}; send(); drain();

        // ModRM + SIB + disp32 + imm32, fed with idle cycles between bytes
        e = '0; e.opcode = 8'h81; e.info = 24'hCDC000; e.modrm = 8'h84; e.sib = 8'h24;
        e.has_modrm = 1'b1; e.has_sib = 1'b1; e.disp = 32'h10; e.imm = 64'h12345678; e.len = 4'd11;
        sb.push_back(e);
        txq = '{8'h81, 8'h84, 8'h24, 8'h10, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        gap = 1'b1; send(); gap = 1'b0; drain();

        // mod=00 with SIB base=101 forces disp32
        e = '0; e.opcode = 8'h81; e.info = 24'hCDC000; e.modrm = 8'h04; e.sib = 8'h25;
        e.has_modrm = 1'b1; e.has_sib = 1'b1; e.disp = 32'h11223344; e.imm = 64'h1; e.len = 4'd11;
        sb.push_back(e);
        txq = '{8'h81, 8'h04, 8'h25, 8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h00, 8'h00, 8'h00};
        send(); drain();

        // Unknown opcode: error, valid on the following cycle
        e = '0; e.opcode = 8'h10; e.err = 1'b1; e.len = 4'd1;
        sb.push_back(e); txq = '{8'h10}; send();
        check("err_valid_next_cycle", 64'(dec_valid), 64'd1);
        drain();

        // 66 0F B6 /r with negative disp8
        e = '0; e.opcode = 8'hB6; e.esc = 1'b1; e.info = 24'h438000; e.opsz16 = 1'b1;
        e.modrm = 8'h45; e.has_modrm = 1'b1; e.disp = 32'hFFFFFFF8; e.len = 4'd5;
        sb.push_back(e); txq = '{8'h66, 8'h0F, 8'hB6, 8'h45, 8'hF8}; send(); drain();

        // Last rep prefix wins and a legacy prefix after REX discards it
        e = '0; e.opcode = 8'h90; e.info = 24'h800000; e.rep = 2'b10; e.len = 4'd4;
        sb.push_back(e); txq = '{8'hF3, 8'h48, 8'hF2, 8'h90}; send(); drain();

        // Lock plus an ignored segment prefix
        e = '0; e.opcode = 8'h90; e.info = 24'h800000; e.lock = 1'b1; e.len = 4'd3;
        sb.push_back(e); txq = '{8'hF0, 8'h2E, 8'h90}; send(); drain();

        // Fifteen prefixes overrun the length limit
        e = '0; e.opsz16 = 1'b1; e.err = 1'b1; e.len = 4'd15;
        sb.push_back(e);
        txq.delete();
        repeat (15) txq.push_back(8'h66);
        send(); drain();

        // Consumer back-pressure: outputs hold and input is refused
        dec_ready = 1'b0;
        e = '0; e.opcode = 8'h90; e.info = 24'h800000; e.len = 4'd1;
        sb.push_back(e); txq = '{8'h90}; send();
        for (int k = 0; k < 3; k++) begin
            check("stall_valid",    64'(dec_valid),  64'd1);
            check("stall_in_ready", 64'(in_ready),   64'd0);
            check("stall_opcode",   64'(dec_opcode), 64'h90);
            check("stall_len",      64'(dec_len),    64'd1);
            @(posedge clk); #1;
        end
        dec_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 64'(in_ready),  64'd1);
        check("release_valid",    64'(dec_valid), 64'd0);
        drain();

        // Reset in the middle of an instruction
        txq = '{8'h48, 8'h81}; send();
        check("pre_reset_len", 64'(dec_len), 64'd2);
        reset = 1'b0;
        #2;
        check("mid_rst_in_ready", 64'(in_ready),   64'd1);
        check("mid_rst_valid",    64'(dec_valid),  64'd0);
        check("mid_rst_rex",      64'(dec_rex),    64'd0);
        check("mid_rst_opcode",   64'(dec_opcode), 64'd0);
        check("mid_rst_info",     64'(dec_info),   64'd0);
        check("mid_rst_len",      64'(dec_len),    64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        e = '0; e.opcode = 8'h90; e.info = 24'h800000; e.len = 4'd1;
        sb.push_back(e); txq = '{8'h90}; send(); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
